// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock FIFO built on an inferred dual-port memory.
// The level flags, the error pulses, pop_valid and pop_data are all registered.
// Define FIFO_FWFT_EN for first-word-fall-through reads. In that mode the head
// word is prefetched into pop_data, and count includes the presented word.
module fifo_buffer #(
  parameter int WIDTH              = 8,
  parameter int DEPTH              = 512,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 4,
  parameter int ALMOST_EMPTY_LEVEL = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   pop_valid,
  output logic                   full,
  output logic                   almost_full,
  output logic                   empty,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic             pop_valid_q, pop_valid_d;
  logic             push_ok_s, pop_ok_s, rd_en_s;

`ifdef FIFO_FWFT_EN
  logic [WIDTH-1:0] pre_data_q;
  logic             pre_valid_q, pre_valid_d;
  logic [CW-1:0]    mem_words_s;
  logic             out_load_s;

  // The prefetch path runs memory -> prefetch register -> presented head word.
  // It keeps the prefetch stage refilled so that a pop sees no gap in pop_valid.
  always_comb begin
    pop_ok_s    = pop & pop_valid_q;
    mem_words_s = count_q - CW'(pre_valid_q) - CW'(pop_valid_q);
    out_load_s  = pre_valid_q & (~pop_valid_q | pop_ok_s);
    rd_en_s     = (mem_words_s != {CW{1'b0}}) & (~pre_valid_q | out_load_s);
    if (rd_en_s) begin
      pre_valid_d = 1'b1;
    end else if (out_load_s) begin
      pre_valid_d = 1'b0;
    end else begin
      pre_valid_d = pre_valid_q;
    end
    if (out_load_s) begin
      pop_valid_d = 1'b1;
      pop_data_d  = pre_data_q;
    end else if (pop_ok_s) begin
      pop_valid_d = 1'b0;
      pop_data_d  = pop_data_q;
    end else begin
      pop_valid_d = pop_valid_q;
      pop_data_d  = pop_data_q;
    end
  end

  // This is the registered memory read port. It feeds the prefetch stage, and like the memory it is not reset.
  always_ff @(posedge clock) begin
    if (rd_en_s) begin
      pre_data_q <= mem_q[rd_ptr_q];
    end
  end

  // Occupancy of the prefetch stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_valid_q <= 1'b0;
    end else begin
      pre_valid_q <= pre_valid_d;
    end
  end
`else
  // In normal mode the read register doubles as the pop_data output. It holds its value when no pop is accepted.
  always_comb begin
    pop_ok_s    = pop & ~empty_q;
    rd_en_s     = pop_ok_s;
    pop_valid_d = pop_ok_s;
    if (pop_ok_s) begin
      pop_data_d = mem_q[rd_ptr_q];
    end else begin
      pop_data_d = pop_data_q;
    end
  end
`endif

  // Push acceptance, pointer advance (natural power-of-two wrap) and count.
  always_comb begin
    push_ok_s = push & ~full_q;
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d  = rd_en_s   ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // This is the memory write port. Its contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Control state. The flags are computed from next count so they change on the same edge as count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == DEPTH_C);
      empty_q     <= (count_d == {CW{1'b0}});
      af_q        <= (count_d >= AF_C);
      ae_q        <= (count_d <= AE_C);
      ovf_q       <= push & full_q;
      udf_q       <= pop & ~pop_ok_s;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

  assign pop_data     = pop_data_q;
  assign pop_valid    = pop_valid_q;
  assign full         = full_q;
  assign almost_full  = af_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
endmodule

// File: doc/fifo_buffer.md
FIFO_BUFFER -- requirements
Module: fifo_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (1..32).
REQ-002 SHALL have parameter DEPTH, default 512, word capacity; a power of two, 4..4096.
REQ-003 SHALL have parameter ALMOST_FULL_LEVEL, default DEPTH-4, count at or above which almost_full asserts.
REQ-004 SHALL have parameter ALMOST_EMPTY_LEVEL, default 4, count at or below which almost_empty asserts.
REQ-005 SHALL have port clock  input  1  the single clock for all logic; rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port push  input  1  write request.
REQ-008 SHALL have port push_data  input  WIDTH  word to write.
REQ-009 SHALL have port pop  input  1  read request (normal mode) or head acknowledge (FWFT mode).
REQ-010 SHALL have port pop_data  output  WIDTH  read word.
REQ-011 SHALL have port pop_valid  output  1  pop_data qualifier.
REQ-012 SHALL have ports full, almost_full, empty and almost_empty  output  1 each  registered level flags.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  stored words, 0..DEPTH.
REQ-014 SHALL have ports overflow and underflow  output  1 each  one-cycle error pulses.

Function
REQ-015 SHALL store words in an inferred dual-port memory (one write port, one registered read port); memory contents SHALL NOT be reset.
REQ-016 SHALL accept a push iff push=1 and full=0: write push_data at wr_ptr, increment wr_ptr modulo DEPTH.
REQ-017 SHALL accept a pop iff pop=1 and empty=0 (normal mode) or pop=1 and pop_valid=1 (FWFT mode).
REQ-018 SHALL pulse overflow for one cycle on push=1 with full=1; the word SHALL be dropped and state unchanged.
REQ-019 SHALL pulse underflow for one cycle on a pop request not accepted per REQ-017; state unchanged.
REQ-020 SHALL update count on the accepting edge: +1 push only, -1 pop only, unchanged for simultaneous accepted push and pop.
REQ-021 SHALL derive full=(count==DEPTH), empty=(count==0), almost_full=(count>=ALMOST_FULL_LEVEL), almost_empty=(count<=ALMOST_EMPTY_LEVEL), all valid on the same edge as count.
REQ-022 SHALL accept simultaneous push and pop when full=1 only as the pop (push flagged overflow); when empty=1, the push is accepted and the pop flagged underflow.
REQ-023 SHALL wrap rd_ptr and wr_ptr from DEPTH-1 to 0 with no bubble.
REQ-024 Normal mode: pop_data SHALL present the popped word one cycle after the accepting edge, with pop_valid high for exactly that cycle; otherwise pop_data SHALL hold its last value.
REQ-025 SHALL return the word written on an edge for a pop of the same address no earlier than the following edge (no same-cycle read-through).

Reset
REQ-026 reset=1 SHALL immediately clear rd_ptr, wr_ptr, count, full, almost_full, pop_valid, overflow, underflow and pop_data, and set empty=1 and almost_empty=1 (almost_empty follows REQ-021 with count=0).
REQ-027 reset asserted mid-operation SHALL discard all stored words; on the first edge after deassertion, the block SHALL accept a push.

Configuration
REQ-028 Macro FIFO_FWFT_EN defined SHALL enable first-word-fall-through: the head word is prefetched into pop_data; pop_valid=1 whenever a word is presented; pop consumes it; the next word, if any, SHALL be presented after the edge following pop with no gap in pop_valid.
REQ-029 With FIFO_FWFT_EN, a push into an empty FIFO SHALL raise pop_valid 2 cycles after the push edge, and count SHALL include the presented word.
REQ-030 Without FIFO_FWFT_EN, the block SHALL behave per REQ-024 with no prefetch logic.

Verification
REQ-031 Reset, then push 0x11,0x22,0x33 on consecutive cycles, then pop three times -> pop_data 0x11,0x22,0x33, each with pop_valid, one cycle after each pop; count returns to 0 and empty=1.
REQ-032 DEPTH=8: push 8 words -> full=1 and count=8; 9th push -> overflow pulse, count stays 8, later pops return the first 8 words only.
REQ-033 Pop on empty after reset -> underflow pulse, count 0, pop_valid stays 0.
REQ-034 Half full, push and pop every cycle for 3*DEPTH cycles -> count constant, pointers wrap, data order preserved with no loss.
REQ-035 FIFO_FWFT_EN: push 0xA5 into empty -> pop_valid=1 with pop_data=0xA5 two cycles later, no pop asserted; pop -> pop_valid=0 next cycle.
REQ-036 Assert reset with count=5 mid-stream -> all flags at reset values in the same cycle; push 0x7E after release, then pop -> 0x7E.
